// File: rtl/fpu_int_to_fp_if.sv
// Handshake bundle for the integer-to-double converter: operand in, packed double out.
interface fpu_int_to_fp_if;
  localparam int unsigned DATA_W = 64;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              inexact;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, result, inexact
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, inexact
  );
endinterface

// File: rtl/fpu_int_to_fp.sv
// 64-bit integer to IEEE-754 double, round-to-nearest-even.
// Normalizes one bit per cycle; valid/ready handshake on both sides.
module fpu_int_to_fp #(
  parameter int SIGNED_IN = 1
) (
  input  logic            clk,
  input  logic            rst,
  fpu_int_to_fp_if.slave  bus
);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned EXP_W  = 11;
  localparam int unsigned FRAC_W = 52;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(1086);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sgn;
  logic                w_sgn_nxt;
  logic [DATA_W-1:0]   r_mag;
  logic [DATA_W-1:0]   w_mag_nxt;
  logic [EXP_W-1:0]    r_exp;
  logic [EXP_W-1:0]    w_exp_nxt;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   w_result_nxt;
  logic                r_inexact;
  logic                w_inexact_nxt;
  logic                r_in_ready;
  logic                r_out_valid;

  logic                w_sgn_in;
  logic [DATA_W-1:0]   w_mag_in;
  logic                w_lsb;
  logic                w_guard;
  logic                w_sticky;
  logic                w_round_up;
  logic [MANT_W-1:0]   w_frac_inc;
  logic [EXP_W-1:0]    w_exp_rnd;

  // Magnitude of the incoming operand; -2^63 maps onto 2^63 unchanged.
  assign w_sgn_in = (SIGNED_IN != 0) && bus.in_data[DATA_W-1];
  assign w_mag_in = w_sgn_in ? (~bus.in_data + DATA_W'(1)) : bus.in_data;

  // Round on the normalized magnitude; a carry out of frac bumps the exponent.
  assign w_lsb      = r_mag[11];
  assign w_guard    = r_mag[10];
  assign w_sticky   = |r_mag[9:0];
  assign w_round_up = w_guard & (w_sticky | w_lsb);
  assign w_frac_inc = {1'b0, r_mag[62:11]} + MANT_W'(w_round_up);
  assign w_exp_rnd  = r_exp + EXP_W'(w_frac_inc[FRAC_W]);

  always_comb begin
    w_state_nxt   = r_state;
    w_sgn_nxt     = r_sgn;
    w_mag_nxt     = r_mag;
    w_exp_nxt     = r_exp;
    w_result_nxt  = r_result;
    w_inexact_nxt = r_inexact;

    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_sgn_nxt = w_sgn_in;
          w_mag_nxt = w_mag_in;
          if (w_mag_in == '0) begin
            w_result_nxt  = '0;
            w_inexact_nxt = 1'b0;
            w_state_nxt   = DONE;
          end else begin
            w_exp_nxt   = EXP_TOP;
            w_state_nxt = NORM;
          end
        end
      end
      NORM: begin
        if (!r_mag[DATA_W-1]) begin
          w_mag_nxt = {r_mag[DATA_W-2:0], 1'b0};
          w_exp_nxt = r_exp - EXP_W'(1);
        end else begin
          w_state_nxt = ROUND;
        end
      end
      ROUND: begin
        w_exp_nxt     = w_exp_rnd;
        w_result_nxt  = {r_sgn, w_exp_rnd, w_frac_inc[FRAC_W-1:0]};
        w_inexact_nxt = w_guard | w_sticky;
        w_state_nxt   = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sgn       <= 1'b0;
      r_mag       <= '0;
      r_exp       <= '0;
      r_result    <= '0;
      r_inexact   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sgn       <= w_sgn_nxt;
      r_mag       <= w_mag_nxt;
      r_exp       <= w_exp_nxt;
      r_result    <= w_result_nxt;
      r_inexact   <= w_inexact_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.inexact   = r_inexact;
endmodule
